// File: rtl/pipelined_compressor_tree.sv
// pipelined_compressor_tree: three-stage unsigned multi-operand adder.
//   S1: one layer of 5:3 counters (operands left over from the groups of 5 pass through)
//   S2: full-adder carry-save layers down to two vectors
//   S3: final carry-propagate adder into the output register
// All stages advance together whenever in_ready is high.
// Optional accumulate mode: define PIPELINED_COMPRESSOR_TREE_ACCUM_EN.
module pipelined_compressor_tree #(
    parameter int WIDTH = 16,
    parameter int OPS   = 17,
    parameter int ACC_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPS*WIDTH-1:0]   in_ops,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
    ,
    input  logic                   acc_mode,
    input  logic                   acc_clear
`endif
);

    localparam int SW  = WIDTH + $clog2(OPS);
    localparam int G5  = OPS / 5;
    localparam int REM = OPS % 5;
    localparam int N1  = 3 * G5 + REM;

    if (OPS < 3 || OPS > 32) begin : g_bad_ops
        $error("pipelined_compressor_tree: OPS must be in 3..32");
    end
    if (ACC_W < SW) begin : g_bad_acc
        $error("pipelined_compressor_tree: ACC_W must be >= WIDTH + $clog2(OPS)");
    end

    logic [SW-1:0]    s1_vec_d [N1];
    logic [SW-1:0]    s1_vec_q [N1];
    logic             s1_valid_d, s1_valid_q;
    logic [SW-1:0]    s2_a_d, s2_a_q, s2_b_d, s2_b_q;
    logic             s2_valid_d, s2_valid_q;
    logic [ACC_W-1:0] out_sum_d, out_sum_q;
    logic             out_valid_d, out_valid_q;

    logic [2:0]       cnt;
    logic [SW-1:0]    work [N1];
    logic [SW-1:0]    nxt  [N1];
    int unsigned      n;
    logic [SW-1:0]    cpa;
    logic [ACC_W-1:0] sum_ext;

`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
    logic             s1_mode_d, s1_mode_q, s1_clear_d, s1_clear_q;
    logic             s2_mode_d, s2_mode_q, s2_clear_d, s2_clear_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [ACC_W-1:0] prior;
`endif

    // Stalls are global: the whole pipe moves only when the output slot can drain.
    assign in_ready  = !out_valid_q || out_ready;
    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;

    // Stage 1: 5:3 counters per bit column; count bits land at weights 1, 2, 4.
    always_comb begin
        cnt        = '0;
        s1_valid_d = s1_valid_q;
        for (int unsigned j = 0; j < N1; j++) s1_vec_d[j] = s1_vec_q[j];
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
        s1_mode_d  = s1_mode_q;
        s1_clear_d = s1_clear_q;
`endif
        if (in_ready) begin
            s1_valid_d = in_valid;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
            s1_mode_d  = acc_mode;
            s1_clear_d = acc_clear;
`endif
            for (int unsigned j = 0; j < N1; j++) s1_vec_d[j] = '0;
            for (int unsigned g = 0; g < G5; g++) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    cnt = 3'(in_ops[(5*g+0)*WIDTH+i]) + 3'(in_ops[(5*g+1)*WIDTH+i])
                        + 3'(in_ops[(5*g+2)*WIDTH+i]) + 3'(in_ops[(5*g+3)*WIDTH+i])
                        + 3'(in_ops[(5*g+4)*WIDTH+i]);
                    s1_vec_d[3*g][i]     = cnt[0];
                    s1_vec_d[3*g+1][i+1] = cnt[1];
                    s1_vec_d[3*g+2][i+2] = cnt[2];
                end
            end
            for (int unsigned r = 0; r < REM; r++)
                s1_vec_d[3*G5+r] = SW'(in_ops[(5*G5+r)*WIDTH +: WIDTH]);
        end
    end

    // Stage 2: repeated 3:2 layers until two vectors remain.
    // The vector count per layer depends only on parameters, so the loop unrolls to a fixed tree.
    always_comb begin
        for (int unsigned j = 0; j < N1; j++) begin
            work[j] = s1_vec_q[j];
            nxt[j]  = '0;
        end
        n = N1;
        for (int unsigned l = 0; l < N1; l++) begin
            if (n > 2) begin
                for (int unsigned j = 0; j < N1; j++) nxt[j] = '0;
                for (int unsigned g = 0; g < N1 / 3; g++) begin
                    if (3*g + 2 < n) begin
                        nxt[2*g]   = work[3*g] ^ work[3*g+1] ^ work[3*g+2];
                        nxt[2*g+1] = ((work[3*g] & work[3*g+1]) | (work[3*g] & work[3*g+2])
                                    | (work[3*g+1] & work[3*g+2])) << 1;
                    end
                end
                for (int unsigned r = 0; r < 2; r++)
                    if (r < n % 3) nxt[2*(n/3)+r] = work[3*(n/3)+r];
                for (int unsigned j = 0; j < N1; j++) work[j] = nxt[j];
                n = 2 * (n / 3) + n % 3;
            end
        end
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        s2_valid_d = s2_valid_q;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
        s2_mode_d  = s2_mode_q;
        s2_clear_d = s2_clear_q;
`endif
        if (in_ready) begin
            s2_a_d     = work[0];
            s2_b_d     = work[1];
            s2_valid_d = s1_valid_q;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
            s2_mode_d  = s1_mode_q;
            s2_clear_d = s1_clear_q;
`endif
        end
    end

    // Stage 3: carry-propagate add, optional accumulate, load output register on valid slots.
    always_comb begin
        cpa         = s2_a_q + s2_b_q;
        sum_ext     = ACC_W'(cpa);
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
        acc_d       = acc_q;
        prior       = s2_clear_q ? '0 : acc_q;
`endif
        if (in_ready) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_sum_d = sum_ext;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
                if (s2_mode_q) begin
                    out_sum_d = prior + sum_ext;
                    acc_d     = prior + sum_ext;
                end else if (s2_clear_q) begin
                    acc_d = '0;
                end
`endif
            end
        end
    end

    // Control state and output register, synchronously reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
            acc_q       <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    // Datapath registers; contents are qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N1; j++) s1_vec_q[j] <= s1_vec_d[j];
        s2_a_q <= s2_a_d;
        s2_b_q <= s2_b_d;
`ifdef PIPELINED_COMPRESSOR_TREE_ACCUM_EN
        s1_mode_q  <= s1_mode_d;
        s1_clear_q <= s1_clear_d;
        s2_mode_q  <= s2_mode_d;
        s2_clear_q <= s2_clear_d;
`endif
    end

endmodule
